regfile_wb: RTL and testbench
=============================

# regfile_wb

Register file with a one-entry write-back staging register and a post-reset clear sequencer. Sits directly downstream of the write-back multiplexers: the 5-bit destination-register mux drives `wr_addr`; the 32-bit result mux drives `wr_data`. It supplies both source operands to the decode/execute stage.

## Interface
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register address width
- `NREGS`, 32, number of architectural registers (`2**ADDR_W`)

Reset is synchronous and active-high; single clock domain.

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `wr_en`  in  1  write request this cycle
- `wr_addr`  in  `ADDR_W`  destination register (from the 5-bit mux)
- `wr_data`  in  `DATA_W`  write data (from the 32-bit mux)
- `rd_addr1`  in  `ADDR_W`  source register 1
- `rd_addr2`  in  `ADDR_W`  source register 2
- `rd_data1`  out  `DATA_W`  source value 1, combinational
- `rd_data2`  out  `DATA_W`  source value 2, combinational
- `busy`  out  1  clear sequence in progress

## Operation
- States: `RF_CLEAR`, `RF_READY`.
- `reset` high at an edge:
  - state ← `RF_CLEAR`, clear counter `cnt` ← 1, staging valid ← 0.
  - Array contents are not touched by reset itself.
- `RF_CLEAR`:
  - Each edge writes 0 to `reg[cnt]`, then `cnt` ← `cnt`+1.
  - On the edge that clears `reg[NREGS-1]`, state ← `RF_READY`.
  - `wr_en` is ignored and nothing is staged.
  - `rd_data1` and `rd_data2` are 0.
- `RF_READY`, each edge:
  - If staging is valid, commit `stg_data` to `reg[stg_addr]`.
  - Then stage `{wr_en && wr_addr != 0, wr_addr, wr_data}`.
- Register 0:
  - Hardwired zero; always reads 0.
  - Writes to address 0 are never staged.
- Same-address back-to-back writes: the old staged value commits and the new value is staged in the same edge; the final array value is the newer write.
- Read path, per port:
  - Address 0 → 0.
  - Otherwise, when bypass is compiled in and staging is valid with `stg_addr` = `rd_addr` → `stg_data`.
  - Otherwise → `reg[rd_addr]`.
- Both ports are independent; identical addresses on both ports are legal.
- `reset` asserted mid-clear or mid-operation:
  - Clear restarts from `cnt` = 1.
  - Any staged write is discarded and never committed.

## Timing
- Reset values: `busy` = 1, `rd_data1` = `rd_data2` = 0, staging valid = 0.
- `busy` is high from the reset edge until the edge that clears register `NREGS-1`. That is `NREGS-1` (= 31) edges after the last reset edge.
- Write captured at edge N (staged), committed at edge N+1.
- Read visibility of a write captured at edge N:
  - With bypass: visible after edge N.
  - Without bypass: visible after edge N+1.
- Read ports are purely combinational from address to data; no read latency.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: read ports forward `stg_data` on an address match, giving an effective one-cycle write-to-read latency.
- Undefined: no forwarding; reads see only the array, so write-to-read latency is two edges. Downstream hazard logic must cover the extra cycle.

## Structure
- Shared package `regfile_pkg` holds:
  - constants `DATA_W`, `ADDR_W`, `NREGS`;
  - state enum `rf_state_t` {`RF_CLEAR`, `RF_READY`}.
- One sub-module, `rf_read_port`: zero check plus optional bypass mux plus array select. It is instantiated twice.
- Clear FSM, counter, staging register and array live in the top module.

## Test plan
- Reset for 1 cycle, then release → `busy` = 1 for exactly 31 edges, then 0; read r1…r31 → all 0.
- After ready, write r5 = 0xDEADBEEF at edge N, read r5 → 0xDEADBEEF after edge N with bypass, and only after edge N+1 without bypass.
- Write r0 = 0xFFFFFFFF, then read r0 on both ports → 0; staging valid stays 0.
- Back-to-back writes r7 = 0x1 then r7 = 0x2, then idle 2 cycles → r7 reads 0x2; the intermediate read after the first edge shows 0x1 (bypass build).
- `wr_en` = 1 to r3 = 0x55 while `busy` = 1 → write dropped; r3 reads 0 after ready.
- Reset asserted at `cnt` = 10 with r20 previously holding 0xABCD → clear restarts; `busy` high for 31 more edges; r20 reads 0 afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and clear-FSM state type for the write-back register file.
package regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: r0/clear forcing, optional staging bypass, array select.
// Forwarding from the staging register is compiled in with REGFILE_BYPASS_EN.
module rf_read_port
    import regfile_pkg::*;
(
    input  logic              hold_zero,
    input  logic [ADDR_W-1:0] addr,
    input  logic              stg_valid,
    input  logic [ADDR_W-1:0] stg_addr,
    input  logic [DATA_W-1:0] stg_data,
    input  logic [DATA_W-1:0] regs [NREGS],
    output logic [DATA_W-1:0] data
);

`ifndef REGFILE_BYPASS_EN
    logic unused_stg;
    assign unused_stg = ^{stg_valid, stg_addr, stg_data};
`endif

    always_comb begin
        data = regs[addr];
`ifdef REGFILE_BYPASS_EN
        if (stg_valid && (stg_addr == addr)) begin
            data = stg_data;
        end
`endif
        // r0 is never written, so its array slot is never trusted.
        if (hold_zero || (addr == '0)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Register file with one-entry write-back staging and a post-reset clear sequencer.
// Optional read bypass of the staged write: define REGFILE_BYPASS_EN.
module regfile_wb
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy
);

    rf_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              stg_valid_reg, stg_valid_next;
    logic [ADDR_W-1:0] stg_addr_reg, stg_addr_next;
    logic [DATA_W-1:0] stg_data_reg, stg_data_next;

    logic [DATA_W-1:0] mem [NREGS];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        stg_valid_next = stg_valid_reg;
        stg_addr_next  = stg_addr_reg;
        stg_data_next  = stg_data_reg;
        mem_we         = 1'b0;
        mem_waddr      = cnt_reg;
        mem_wdata      = '0;
        case (state_reg)
            RF_CLEAR: begin
                mem_we         = 1'b1;
                cnt_next       = cnt_reg + ADDR_W'(1);
                stg_valid_next = 1'b0;
                if (cnt_reg == ADDR_W'(NREGS - 1)) begin
                    state_next = RF_READY;
                end
            end
            RF_READY: begin
                mem_we         = stg_valid_reg;
                mem_waddr      = stg_addr_reg;
                mem_wdata      = stg_data_reg;
                stg_valid_next = wr_en && (wr_addr != '0);
                stg_addr_next  = wr_addr;
                stg_data_next  = wr_data;
            end
            default: state_next = RF_CLEAR;
        endcase
        // A reset edge leaves the array alone and drops any staged write.
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RF_CLEAR;
            cnt_reg       <= ADDR_W'(1);
            stg_valid_reg <= 1'b0;
            stg_addr_reg  <= '0;
            stg_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            stg_valid_reg <= stg_valid_next;
            stg_addr_reg  <= stg_addr_next;
            stg_data_reg  <= stg_data_next;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign busy = (state_reg == RF_CLEAR);

    logic [ADDR_W-1:0] rd_addr_arr [2];
    logic [DATA_W-1:0] rd_data_arr [2];

    assign rd_addr_arr[0] = rd_addr1;
    assign rd_addr_arr[1] = rd_addr2;
    assign rd_data1       = rd_data_arr[0];
    assign rd_data2       = rd_data_arr[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            rf_read_port u_port (
                .hold_zero (busy),
                .addr      (rd_addr_arr[gi]),
                .stg_valid (stg_valid_reg),
                .stg_addr  (stg_addr_reg),
                .stg_data  (stg_data_reg),
                .regs      (mem),
                .data      (rd_data_arr[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: a visibility-level model checked every cycle plus literal expectations.
module tb_regfile_wb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rd_addr1 = '0;
    logic [4:0]  rd_addr2 = '0;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        busy;

    int checks = 0;
    int errors = 0;

    regfile_wb dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: what software-visible state must look like, per edge.
    logic [31:0] m_arch [32];
    int          clear_left = 0;
    bit          model_on = 1'b0;
    bit          pend_v = 1'b0;
    logic [4:0]  pend_a = '0;
    logic [31:0] pend_d = '0;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (clear_left > 0 || a == 5'd0) return 32'h0;
        if (BYP && pend_v && pend_a == a) return pend_d;
        return m_arch[a];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            model_on   = 1'b1;
            clear_left = 31;
            pend_v     = 1'b0;
        end else if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) begin
                for (int i = 0; i < 32; i++) m_arch[i] = 32'h0;
            end
        end else begin
            if (pend_v) m_arch[pend_a] = pend_d;
            pend_v = wr_en && (wr_addr != 5'd0);
            pend_a = wr_addr;
            pend_d = wr_data;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("busy", {31'b0, busy}, {31'b0, (clear_left > 0)});
            check("rd_data1", rd_data1, exp_rd(rd_addr1));
            check("rd_data2", rd_data2, exp_rd(rd_addr2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        $display("reset pulse");
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check(name, n, 31);
        $display("clear done after %0d edges", n);
    endtask

    task automatic set_write(input logic en, input logic [4:0] a, input logic [31:0] d);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        if (en) $display("write r%0d = %h", a, d);
    endtask

    initial begin
        // Reset and full clear
        do_reset();
        check("busy_after_reset", {31'b0, busy}, 32'd1);
        check("rd_during_clear", rd_data1, 32'h0);
        wait_ready("clear_edges_first");
        for (int i = 1; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(31 - i + 1);
            #1;
            check("cleared_p1", rd_data1, 32'h0);
            check("cleared_p2", rd_data2, 32'h0);
        end

        // r5 latency
        rd_addr1 = 5'd5;
        rd_addr2 = 5'd5;
        set_write(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        set_write(1'b0, 5'd0, 32'h0);
        #1;
        check("r5_after_N", rd_data1, BYP ? 32'hDEADBEEF : 32'h0);
        tick();
        check("r5_after_N1", rd_data2, 32'hDEADBEEF);

        // r0 write is dropped
        set_write(1'b1, 5'd0, 32'hFFFFFFFF);
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        tick();
        set_write(1'b0, 5'd0, 32'h0);
        #1;
        check("r0_p1", rd_data1, 32'h0);
        check("r0_p2", rd_data2, 32'h0);
        check("r0_not_staged", {31'b0, dut.stg_valid_reg}, 32'd0);
        tick();
        check("r0_p1_later", rd_data1, 32'h0);

        // Back-to-back r7 writes
        rd_addr1 = 5'd7;
        rd_addr2 = 5'd5;
        set_write(1'b1, 5'd7, 32'h1);
        tick();
        set_write(1'b1, 5'd7, 32'h2);
        #1;
        check("r7_first", rd_data1, BYP ? 32'h1 : 32'h0);
        tick();
        set_write(1'b0, 5'd0, 32'h0);
        #1;
        check("r7_second", rd_data1, BYP ? 32'h2 : 32'h1);
        tick();
        tick();
        check("r7_final", rd_data1, 32'h2);
        check("r5_indep_port", rd_data2, 32'hDEADBEEF);

        // Writes during clear are ignored
        do_reset();
        set_write(1'b1, 5'd3, 32'h55);
        wait_ready("clear_edges_wr_ignored");
        set_write(1'b0, 5'd0, 32'h0);
        rd_addr1 = 5'd3;
        rd_addr2 = 5'd5;
        tick();
        tick();
        check("r3_dropped", rd_data1, 32'h0);
        check("r5_recleared", rd_data2, 32'h0);

        // Reset mid-clear at cnt = 10
        set_write(1'b1, 5'd20, 32'hABCD);
        rd_addr1 = 5'd20;
        tick();
        set_write(1'b0, 5'd0, 32'h0);
        tick();
        check("r20_written", rd_data1, 32'hABCD);
        do_reset();
        for (int i = 0; i < 9; i++) tick();
        check("busy_mid_clear", {31'b0, busy}, 32'd1);
        do_reset();
        wait_ready("clear_edges_restart");
        check("r20_cleared", rd_data1, 32'h0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
